dot_prod: RTL and testbench
===========================

// Module: dot_prod
//
// PURPOSE
//   Pipelined signed 3-element dot product: p = a0*b0 + a1*b1 + a2*b2.
//   Accepts a new operand set every clock and produces one result per clock.
//   Used as a small DSP kernel, e.g. filter taps or colour-space dot products.
//   No valid/ready handshake; the consumer aligns results by the fixed latency.
//
// PARAMETERS
//   AW  9  width of each signed a operand (two's complement), AW >= 2
//   BW  9  width of each signed b operand (two's complement), BW >= 2
//
// PORTS
//   clk  in   1          rising-edge clock, the only clock in the block
//   rst  in   1          asynchronous reset, active-high
//   a0   in   AW signed  operand vector A, element 0
//   a1   in   AW signed  operand vector A, element 1
//   a2   in   AW signed  operand vector A, element 2
//   b0   in   BW signed  operand vector B, element 0
//   b1   in   BW signed  operand vector B, element 1
//   b2   in   BW signed  operand vector B, element 2
//   p    out  AW+BW+2 signed  registered dot-product result
//
// BEHAVIOUR
//   - All arithmetic is signed and exact; the block never truncates or saturates.
//     * Each product is AW+BW bits.
//     * The 3-term sum is AW+BW+2 bits, which holds 3*(-2^(AW-1))*(-2^(BW-1)).
//   - Three register stages; latency is exactly 3 clk rising edges.
//     * S1: register a0..a2 and b0..b2 (sampled on rising edge N).
//     * S2: register the three products m_i = a_i * b_i, sign-extended.
//     * S3: register p = m0 + m1 + m2.
//     * The result for operands sampled at edge N appears on p after edge N+2
//       and is valid for the whole following cycle.
//   - Throughput is 1 result per cycle, with no bubbles and no stall input.
//   - p changes only on rising clk edges or on reset; there is no combinational
//     path from any input to p.
//   - Reset:
//     * rst=1 clears all S1/S2/S3 registers to 0 immediately, independent of clk.
//     * p reads 0 while rst is high.
//     * After release, p stays 0 until the first post-reset operands reach S3,
//       i.e. 0 is the sum of zero operands.
//     * Reset asserted mid-stream discards all in-flight results.
//   - Boundary cases:
//     * Most negative operands: (-2^(AW-1))*(-2^(BW-1)) is a positive product
//       and must not wrap.
//     * All-zero operands give p=0.
//     * Inputs that are X before the first edge after reset propagate only
//       through the pipeline, never to p asynchronously.
//
// STRUCTURE
//   - Package dot_prod_pkg:
//     * localparam int DOT_PROD_LAT = 3.
//     * Helper function prod_w(aw,bw) = aw+bw and sum_w(aw,bw) = aw+bw+2,
//       so that benches and instantiators size p identically.
//   - Sub-module dot_prod_mul #(AW,BW):
//     * Registered signed multiplier with async reset (S1 operand regs + S2
//       product reg).
//     * Instantiated 3 times; the top level holds the S3 adder register.
//     * Keeps each mul in its own DSP slice.
//
// TESTING (AW=BW=9; compare p against a reference model delayed DOT_PROD_LAT)
//   1. Reset: rst=1 mid-stream -> p=0 immediately without a clk edge. After
//      release with zero inputs, p stays 0.
//   2. a=(1,2,3), b=(4,5,6) held for one cycle at edge N -> p=32 after edge
//      N+2; p=0 before that.
//   3. a=(-10,10,-10), b=(10,10,-10) -> p=100.
//      a=(-10,-10,-10), b=(10,10,10) -> p=-300.
//   4. Extremes:
//      - a=b=(-256,-256,-256) -> p=196608, with no wrap.
//      - a=(-256,-256,-256), b=(255,255,255) -> p=-195840.
//   5. Back-to-back stream of 16 cycles with $urandom_range(-10,10) on all six
//      inputs -> p matches the model every cycle, with no gaps.
//   6. Assert rst for 1 cycle in the middle of scenario 5 -> the three in-flight
//      results read 0. Results resume correctly 3 edges after the first
//      post-reset sample.

Source files
------------

// File: rtl/dot_prod_pkg.sv
// Shared definitions for the dot_prod pipeline.
//   DOT_PROD_LAT : clock edges from operand sample to result on p
//   prod_w()     : width of one exact signed product a_i*b_i
//   sum_w()      : width of the exact signed three-term sum (two guard bits)
package dot_prod_pkg;

   localparam int DOT_PROD_LAT = 3;

   function automatic int prod_w(input int aw, input int bw);
      return aw + bw;
   endfunction

   function automatic int sum_w(input int aw, input int bw);
      return aw + bw + 2;
   endfunction

endpackage

// File: rtl/dot_prod_mul.sv
// Registered signed multiplier, one per dot-product term.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   a, b     : signed operands, sampled into the S1 registers
//   m        : registered exact product (S2), prod_w(AW,BW) bits
module dot_prod_mul
   import dot_prod_pkg::*;
#(
   parameter int AW = 9,
   parameter int BW = 9
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic signed [AW-1:0]            a,
   input  logic signed [BW-1:0]            b,
   output logic signed [prod_w(AW,BW)-1:0] m
);

   localparam int PW = prod_w(AW, BW);

   logic signed [AW-1:0] a_d, a_q;
   logic signed [BW-1:0] b_d, b_q;
   logic signed [PW-1:0] a_x, b_x;
   logic signed [PW-1:0] m_d, m_q;

   // Operands are sign-extended to the full product width first, so the
   // multiply is evaluated at PW bits and the most-negative squared case
   // lands as a positive value instead of wrapping.
   always_comb begin
      a_d = a;
      b_d = b;
      a_x = PW'(a_q);
      b_x = PW'(b_q);
      m_d = a_x * b_x;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         m_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         m_q <= m_d;
      end
   end

   assign m = m_q;

endmodule

// File: rtl/dot_prod.sv
// Pipelined signed 3-element dot product p = a0*b0 + a1*b1 + a2*b2.
// One operand set accepted and one result produced per clock; latency is
// DOT_PROD_LAT edges (S1 operands, S2 products, S3 sum). No handshake.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   a0..a2     : signed AW-bit operand vector A
//   b0..b2     : signed BW-bit operand vector B
//   p          : registered exact sum, sum_w(AW,BW) bits
module dot_prod
   import dot_prod_pkg::*;
#(
   parameter int AW = 9,
   parameter int BW = 9
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic signed [AW-1:0]           a0,
   input  logic signed [AW-1:0]           a1,
   input  logic signed [AW-1:0]           a2,
   input  logic signed [BW-1:0]           b0,
   input  logic signed [BW-1:0]           b1,
   input  logic signed [BW-1:0]           b2,
   output logic signed [sum_w(AW,BW)-1:0] p
);

   localparam int PW = prod_w(AW, BW);
   localparam int SW = sum_w(AW, BW);

   logic signed [PW-1:0] m0, m1, m2;
   logic signed [SW-1:0] p_d, p_q;

   dot_prod_mul #(.AW(AW), .BW(BW)) u_mul0 (.clk(clk), .rst(rst), .a(a0), .b(b0), .m(m0));
   dot_prod_mul #(.AW(AW), .BW(BW)) u_mul1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .m(m1));
   dot_prod_mul #(.AW(AW), .BW(BW)) u_mul2 (.clk(clk), .rst(rst), .a(a2), .b(b2), .m(m2));

   // Products are sign-extended by two bits so three worst-case terms sum exactly.
   always_comb begin
      p_d = SW'(m0) + SW'(m1) + SW'(m2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p = p_q;

endmodule

// File: tb/tb_dot_prod.sv
module tb_dot_prod;
   import dot_prod_pkg::*;

   localparam int AW = 9;
   localparam int BW = 9;
   localparam int SW = sum_w(AW, BW);

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic signed [AW-1:0] a0, a1, a2;
   logic signed [BW-1:0] b0, b1, b2;
   logic signed [SW-1:0] p;

   int checks   = 0;
   int failures = 0;

   // Reference history: exact dot products of the operand sets sampled since
   // the last reset, oldest first, trimmed to the pipeline depth.
   int hist[$];

   always #5 clk = ~clk;

   dot_prod #(.AW(AW), .BW(BW)) dut (
      .clk(clk), .rst(rst),
      .a0(a0), .a1(a1), .a2(a2),
      .b0(b0), .b1(b1), .b2(b2),
      .p(p)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: p=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int dot3(input int x0, input int x1, input int x2,
                               input int y0, input int y1, input int y2);
      return x0 * y0 + x1 * y1 + x2 * y2;
   endfunction

   // Drive one operand set, let one rising edge pass, update the model and
   // compare p on the following falling edge.
   task automatic step(input string tag, input int x0, input int x1, input int x2,
                       input int y0, input int y1, input int y2);
      int e;
      a0 = AW'(x0); a1 = AW'(x1); a2 = AW'(x2);
      b0 = BW'(y0); b1 = BW'(y1); b2 = BW'(y2);
      @(posedge clk);
      if (rst) begin
         hist.delete();
      end else begin
         hist.push_back(dot3(x0, x1, x2, y0, y1, y2));
         if (hist.size() > DOT_PROD_LAT) void'(hist.pop_front());
      end
      e = (hist.size() == DOT_PROD_LAT) ? hist[0] : 0;
      @(negedge clk);
      chk(tag, 32'(p), e);
   endtask

   function automatic int rnd(input int lo, input int hi);
      return int'($urandom_range(32'(hi - lo), 0)) + lo;
   endfunction

   int ta[5][6] = '{'{1, 2, 3, 4, 5, 6},
                    '{-10, 10, -10, 10, 10, -10},
                    '{-10, -10, -10, 10, 10, 10},
                    '{-256, -256, -256, -256, -256, -256},
                    '{-256, -256, -256, 255, 255, 255}};
   int te[5] = '{32, 100, -300, 196608, -195840};

   initial begin
      a0 = '0; a1 = '0; a2 = '0;
      b0 = '0; b1 = '0; b2 = '0;

      // Initial reset asserted between edges: p must clear without a clock.
      #2 rst = 1'b1;
      #1 chk("reset_init", 32'(p), 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Zero inputs after release keep p at zero.
      for (int i = 0; i < 4; i++) step("post_reset_zero", 0, 0, 0, 0, 0, 0);

      // Single-cycle operand set: zero for two edges, then 32.
      step("dir_lat0", 1, 2, 3, 4, 5, 6);
      chk("dir_lat0_const", 32'(p), 0);
      step("dir_lat1", 0, 0, 0, 0, 0, 0);
      chk("dir_lat1_const", 32'(p), 0);
      step("dir_lat2", 0, 0, 0, 0, 0, 0);
      chk("dir_lat2_const", 32'(p), 32);
      step("dir_flush", 0, 0, 0, 0, 0, 0);
      chk("dir_flush_const", 32'(p), 0);

      // Directed sets back-to-back, including the extremes.
      for (int i = 0; i < 7; i++) begin
         if (i < 5) step("dir_table", ta[i][0], ta[i][1], ta[i][2], ta[i][3], ta[i][4], ta[i][5]);
         else       step("dir_table", 0, 0, 0, 0, 0, 0);
         if (i >= 2) chk("dir_table_const", 32'(p), te[i-2]);
      end

      // Small-range random stream, no gaps.
      for (int i = 0; i < 16; i++)
         step("rand_small", rnd(-10, 10), rnd(-10, 10), rnd(-10, 10),
                            rnd(-10, 10), rnd(-10, 10), rnd(-10, 10));

      // Same stream with a one-cycle reset in the middle.
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            rst = 1'b1;
            #1 chk("reset_async", 32'(p), 0);
         end
         step("rand_rst", rnd(-10, 10), rnd(-10, 10), rnd(-10, 10),
                          rnd(-10, 10), rnd(-10, 10), rnd(-10, 10));
         if (i == 8) rst = 1'b0;
      end

      // Full-range random stream.
      for (int i = 0; i < 24; i++)
         step("rand_full", rnd(-256, 255), rnd(-256, 255), rnd(-256, 255),
                           rnd(-256, 255), rnd(-256, 255), rnd(-256, 255));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard bound on run time in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
